// File: rtl/audio_pkg.sv
// Shared widths, sample type and conversion/saturation helpers for the
// audio DC-removal mixer.
package audio_pkg;
   localparam int IN_W_DEF     = 16;
   localparam int OUT_W_DEF    = 16;
   localparam int DC_SHIFT_DEF = 10;

   typedef logic signed [OUT_W_DEF-1:0] sample_t;

   typedef struct packed {
      logic    clipped;
      sample_t sample;
   } sat_res_t;

   // Offset-binary to two's complement: flipping the MSB recentres midscale on zero.
   function automatic logic signed [IN_W_DEF-1:0] u2s(input logic [IN_W_DEF-1:0] u);
      return {~u[IN_W_DEF-1], u[IN_W_DEF-2:0]};
   endfunction

   // The value fits when every bit above the output sign bit matches the sign.
   function automatic sat_res_t sat_to_out(input logic signed [IN_W_DEF:0] v);
      sat_res_t res;
      res.clipped = 1'b0;
      res.sample  = v[OUT_W_DEF-1:0];
      if (v[IN_W_DEF:OUT_W_DEF-1] != {(IN_W_DEF-OUT_W_DEF+2){v[IN_W_DEF]}}) begin
         res.clipped = 1'b1;
         res.sample  = v[IN_W_DEF] ? {1'b1, {(OUT_W_DEF-1){1'b0}}}
                                   : {1'b0, {(OUT_W_DEF-1){1'b1}}};
      end
      return res;
   endfunction
endpackage

// File: rtl/sample_fifo.sv
// Show-ahead FIFO: the head word is visible on dout whenever the FIFO is
// non-empty, and reads zero when empty.
module sample_fifo #(
   parameter int  DEPTH = 4,
   parameter int  W     = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  level
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == (AW+1)'(DEPTH));
   assign level = level_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/audio_dc_mixer.sv
// Per-sample DC removal, shift attenuation, mute and saturation of the sound
// block output, buffered as duplicated-mono stereo toward the audio sink.
module audio_dc_mixer
   import audio_pkg::*;
#(
   parameter int  IN_W       = IN_W_DEF,
   parameter int  OUT_W      = OUT_W_DEF,
   parameter int  DC_SHIFT   = DC_SHIFT_DEF,
   parameter int  FIFO_DEPTH = 4,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_48KHz_en,
   input  logic [IN_W-1:0]         audio_in,
   input  logic                    mute,
   input  logic [2:0]              volume,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_l,
   output logic signed [OUT_W-1:0] out_r,
   output logic [LVL_W-1:0]        fifo_level,
   output logic [7:0]              drop_cnt,
   output logic [7:0]              sat_cnt
);
   localparam int ACC_W = IN_W + DC_SHIFT + 1;

   logic                    v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
   logic signed [IN_W-1:0]  x_q, x_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [IN_W:0]    y_q, y_d;
   sample_t                 s_q, s_d;
   logic [7:0]              sat_cnt_q, sat_cnt_d;
   logic [7:0]              drop_cnt_q, drop_cnt_d;
   logic signed [ACC_W-1:0] est, diff;
   logic signed [IN_W:0]    v;
   sat_res_t                sat;
   logic                    fifo_full, fifo_empty, pop;
   sample_t                 head;

   // Handshake: a sample transfers on every clk where out_valid and out_ready
   // are both 1; out_valid never depends on out_ready, and out_ready is
   // ignored while out_valid is 0.
   assign out_valid  = ~fifo_empty;
   assign pop        = out_valid & out_ready;
   assign out_l      = head;
   assign out_r      = head;
   assign drop_cnt   = drop_cnt_q;
   assign sat_cnt    = sat_cnt_q;

   always_comb begin
      x_d  = clk_48KHz_en ? u2s(audio_in) : x_q;
      v0_d = clk_48KHz_en;

      // One-pole high-pass: acc tracks the input scaled by 2^DC_SHIFT.
      est   = acc_q >>> DC_SHIFT;
      diff  = {{(ACC_W-IN_W){x_q[IN_W-1]}}, x_q} - est;
      acc_d = v0_q ? acc_q + diff : acc_q;
      y_d   = v0_q ? diff[IN_W:0] : y_q;
      v1_d  = v0_q;

      v         = y_q >>> volume;
      sat       = sat_to_out(v);
      s_d       = s_q;
      sat_cnt_d = sat_cnt_q;
      if (v1_q) begin
         s_d = mute ? '0 : sat.sample;
         if (!mute && sat.clipped && sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
      end
      v2_d = v1_q;

      drop_cnt_d = drop_cnt_q;
      if (v2_q && fifo_full && !pop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         x_q        <= '0;
         acc_q      <= '0;
         y_q        <= '0;
         s_q        <= '0;
         sat_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         y_q        <= y_d;
         s_q        <= s_d;
         sat_cnt_q  <= sat_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (OUT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (v2_q),
      .pop   (pop),
      .din   (s_q),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );
endmodule

// File: doc/audio_dc_mixer.md
Name: audio_dc_mixer

Overview:
- Downstream stage of the sound block. Consumes its 16-bit unsigned offset-binary `audio` word at the 48 kHz sample enable.
- Per sample: removes DC with a one-pole high-pass, applies a shift attenuator, mutes and saturates.
- Buffers signed stereo (duplicated mono) samples in a small FIFO with a valid/ready handshake toward the framework audio sink.

Parameters:
- IN_W, 16, width of input sample (unsigned, midscale = 2^(IN_W-1)).
- OUT_W, 16, width of signed output sample.
- DC_SHIFT, 10, high-pass pole = 1 - 2^-DC_SHIFT.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clk_48KHz_en  in  1  one-clk sample strobe; strobes are >=4 clk apart.
- audio_in  in  IN_W  unsigned sample from sound.
- mute  in  1  force output samples to 0.
- volume  in  3  attenuation: arithmetic right shift 0..7.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts head sample when out_valid=1.
- out_l  out  OUT_W  signed head sample, left.
- out_r  out  OUT_W  signed head sample, right (== out_l).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  8  samples dropped on full FIFO, saturating.
- sat_cnt  out  8  samples clipped by saturation, saturating.

Behaviour:
- Reset (rst=0, async): all pipeline registers, DC accumulator, FIFO pointers and counters = 0. out_valid=0, out_l=out_r=0, fifo_level=0.
- Reset mid-operation discards the in-flight pipeline and FIFO contents. Counting restarts after release.
- S0, on the clk_48KHz_en cycle: register x = {~audio_in[IN_W-1], audio_in[IN_W-2:0]} as signed IN_W.
- S1 (S0+1):
  - est = acc >>> DC_SHIFT; acc is signed IN_W+DC_SHIFT+1 bits.
  - y = x - est, IN_W+1 bits signed.
  - acc <= acc + x - est.
  - The accumulator updates once per sample only.
- S2 (S0+2):
  - v = y >>> volume; volume is sampled this cycle, so changes apply per sample.
  - Saturate v to OUT_W signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If clipped, sat_cnt++ (stops at 255).
  - If mute=1, the sample becomes 0, no sat_cnt increment, and acc still updates.
- S3 (S0+3): push request to FIFO.
  - Latency from strobe to out_valid on an empty FIFO: 4 clk (valid visible the cycle after the write).
- FIFO, show-ahead: out_l/out_r present the head combinationally from storage whenever out_valid=1. They read 0 when empty.
- Pop when out_valid & out_ready.
- Push when full and no pop in the same cycle: the sample is dropped and drop_cnt++ (saturating at 255).
- Push when full with a pop in the same cycle: the push is accepted and level is unchanged.
- Push and pop when empty: push only; no pop, since out_valid=0.
- Pointers wrap modulo FIFO_DEPTH. Level ranges 0..FIFO_DEPTH.
- out_ready while out_valid=0: ignored.
- Strobe spacing below 4 clk is unsupported; the pipeline still advances one stage per clk.

Decomposition:
- Package audio_pkg:
  - IN_W/OUT_W/DC_SHIFT defaults.
  - typedef sample_t (signed OUT_W).
  - Function sat_to_out (clip + flag).
  - Function u2s (offset-binary to signed).
- Sub-module sample_fifo: parameterised DEPTH/W, show-ahead, push/pop/full/empty/level.
- audio_dc_mixer holds the S0..S3 pipeline and the counters.

Test Plan:
- Reset then one strobe with audio_in=0xFFFF, volume=0 → 4 clk later out_valid=1, out_l=out_r=0x7FFF, fifo_level=1; acc=32767.
- Constant audio_in=0x8000 for 100 strobes → every output 0x0000; sat_cnt=0.
- From reset, audio_in=0xC000, volume=1 → first output 0x2000. Then 20000 strobes with out_ready=1 → outputs decay monotonically to within ±2 of 0.
- 20000 strobes of audio_in=0x0000 (est≈-32768), then 0xFFFF → output 0x7FFF, sat_cnt increments by 1.
- out_ready=0, 6 strobes with FIFO_DEPTH=4 → fifo_level=4, drop_cnt=2. Then out_ready=1 → 4 pops in order of the first 4 samples, then out_valid=0.
- Strobe, then rst=0 asserted at S2 → out_valid stays 0 after release, counters=0; mute=1 strobe afterwards → output 0x0000.
